// File: rtl/ndro_bank_scheduler.sv
// NDRO bank scheduler: arbitrates two requesters (round-robin) onto a bank of
// non-destructive-readout cells. Each granted operation drives one set/reset/clk
// pulse, optionally waits for the readout, returns a response and then holds
// the bank idle for GAP cycles. A per-cell shadow bit tracks the expected cell
// state so that reads can flag a mismatch.
module ndro_bank_scheduler #(
    parameter int N_CELLS  = 8,
    parameter int GAP      = 2,
    parameter int READ_LAT = 2,
    localparam int AW      = (N_CELLS > 1) ? $clog2(N_CELLS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_a,
    input  logic               req_b,
    input  logic [1:0]         op_a,
    input  logic [1:0]         op_b,
    input  logic [AW-1:0]      addr_a,
    input  logic [AW-1:0]      addr_b,
    output logic               gnt_a,
    output logic               gnt_b,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic               rsp_data,
    output logic               rsp_err,
    output logic [N_CELLS-1:0] ndro_set,
    output logic [N_CELLS-1:0] ndro_reset,
    output logic [N_CELLS-1:0] ndro_clk,
    input  logic [N_CELLS-1:0] ndro_out,
    output logic               busy
);

    typedef enum logic [1:0] {
        OP_SET   = 2'b00,
        OP_RESET = 2'b01,
        OP_READ  = 2'b10,
        OP_ILL   = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
        ST_RESP,
        ST_HOLD
    } state_t;

    localparam int            CNT_MAX   = (GAP > READ_LAT) ? GAP : READ_LAT;
    localparam int            CW        = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [AW:0]   N_CELLS_L = (AW + 1)'(N_CELLS);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 prio_q;     // 0: A holds priority, 1: B holds priority
    logic                 id_q;       // requester of the operation in flight
    logic                 is_read_q;
    logic [AW-1:0]        addr_q;
    logic [N_CELLS-1:0]   shadow_q;
    logic [N_CELLS-1:0]   ndro_set_q, ndro_reset_q, ndro_clk_q;
    logic                 rsp_valid_q, rsp_id_q, rsp_data_q, rsp_err_q;

    logic                 grant_a, grant_b, granted, sel_b, sel_illegal;
    op_t                  sel_op;
    logic [AW-1:0]        sel_addr;
    logic [N_CELLS-1:0]   sel_onehot;

    // Round-robin grant, only offered while idle and out of reset.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && state_q == ST_IDLE) begin
            if (req_a && (!req_b || !prio_q)) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    assign granted     = grant_a | grant_b;
    assign sel_b       = grant_b;
    assign sel_op      = op_t'(sel_b ? op_b : op_a);
    assign sel_addr    = sel_b ? addr_b : addr_a;
    assign sel_illegal = (sel_op == OP_ILL) || ({1'b0, sel_addr} >= N_CELLS_L);
    assign sel_onehot  = N_CELLS'(1) << sel_addr;

    // Scheduler FSM with registered pulse and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            prio_q       <= 1'b0;
            id_q         <= 1'b0;
            is_read_q    <= 1'b0;
            addr_q       <= '0;
            // NOTE: the shadow array is reset on purpose; its value is architecturally visible through rsp_err.
            shadow_q     <= '0;
            ndro_set_q   <= '0;
            ndro_reset_q <= '0;
            ndro_clk_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state; defaults below make every pulse one cycle wide.
            ndro_set_q   <= '0;
            ndro_reset_q <= '0;
            ndro_clk_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= 1'b0;
            rsp_err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (granted) begin
                        prio_q    <= ~sel_b;
                        id_q      <= sel_b;
                        addr_q    <= sel_addr;
                        is_read_q <= !sel_illegal && (sel_op == OP_READ);
                        state_q   <= ST_ISSUE;
                        if (sel_illegal) begin
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= sel_b;
                            rsp_err_q   <= 1'b1;
                        end else begin
                            case (sel_op)
                                OP_SET: begin
                                    ndro_set_q         <= sel_onehot;
                                    shadow_q[sel_addr] <= 1'b1;
                                    rsp_valid_q        <= 1'b1;
                                    rsp_id_q           <= sel_b;
                                end
                                OP_RESET: begin
                                    ndro_reset_q       <= sel_onehot;
                                    shadow_q[sel_addr] <= 1'b0;
                                    rsp_valid_q        <= 1'b1;
                                    rsp_id_q           <= sel_b;
                                end
                                default: begin
                                    ndro_clk_q <= sel_onehot;
                                end
                            endcase
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_read_q) begin
                        state_q <= ST_WAIT_RD;
                        cnt_q   <= CW'(READ_LAT - 1);
                    end else if (GAP > 0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CW'(GAP - 1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_RD: begin
                    if (cnt_q == '0) begin
                        // Last wait cycle: sample the cell readout.
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= ndro_out[addr_q];
                        rsp_err_q   <= ndro_out[addr_q] ^ shadow_q[addr_q];
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (GAP > 0) begin
                        state_q <= ST_HOLD;
                        cnt_q   <= CW'(GAP - 1);
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gnt_a      = grant_a;
    assign gnt_b      = grant_b;
    assign busy       = (state_q != ST_IDLE);
    assign ndro_set   = ndro_set_q;
    assign ndro_reset = ndro_reset_q;
    assign ndro_clk   = ndro_clk_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ndro_bank_scheduler.sv
// Directed testbench for ndro_bank_scheduler (default parameters).
// Inputs change 2 time units after each rising edge; outputs are checked 1 unit later.
module tb_ndro_bank_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_a, req_b;
    logic [1:0] op_a, op_b;
    logic [2:0] addr_a, addr_b;
    logic       gnt_a, gnt_b;
    logic       rsp_valid, rsp_id, rsp_data, rsp_err;
    logic [7:0] ndro_set, ndro_reset, ndro_clk, ndro_out;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ndro_bank_scheduler #(
        .N_CELLS (8),
        .GAP     (2),
        .READ_LAT(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_a     (req_a),
        .req_b     (req_b),
        .op_a      (op_a),
        .op_b      (op_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ndro_set  (ndro_set),
        .ndro_reset(ndro_reset),
        .ndro_clk  (ndro_clk),
        .ndro_out  (ndro_out),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic skip(input int n);
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic chk_gnt(input string tag, input logic a, input logic b);
        #1;
        check({tag, ".gnt_a"}, gnt_a, a);
        check({tag, ".gnt_b"}, gnt_b, b);
    endtask

    task automatic chk_pulse(input string tag, input logic [7:0] s, input logic [7:0] r,
                             input logic [7:0] c);
        check({tag, ".ndro_set"},   ndro_set,   s);
        check({tag, ".ndro_reset"}, ndro_reset, r);
        check({tag, ".ndro_clk"},   ndro_clk,   c);
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic id, input logic d,
                           input logic e);
        check({tag, ".rsp_valid"}, rsp_valid, v);
        check({tag, ".rsp_id"},    rsp_id,    id);
        check({tag, ".rsp_data"},  rsp_data,  d);
        check({tag, ".rsp_err"},   rsp_err,   e);
    endtask

    initial begin
        reset    = 1'b1;
        req_a    = 1'b0;  req_b  = 1'b0;
        op_a     = 2'b00; op_b   = 2'b00;
        addr_a   = 3'd0;  addr_b = 3'd0;
        ndro_out = 8'h00;

        // Reset state
        skip(2);
        #1;
        check("rst.busy", busy, 1'b0);
        chk_rsp("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_pulse("rst", 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        next_cycle();

        // A SET addr 3
        req_a = 1'b1; op_a = 2'b00; addr_a = 3'd3;
        chk_gnt("set3.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        #1;
        chk_gnt("set3.T1", 1'b0, 1'b0);
        chk_pulse("set3.T1", 8'h08, 8'h00, 8'h00);
        chk_rsp("set3.T1", 1'b1, 1'b0, 1'b0, 1'b0);
        check("set3.T1.busy", busy, 1'b1);
        next_cycle(); #1;
        chk_pulse("set3.T2", 8'h00, 8'h00, 8'h00);
        check("set3.T2.rsp_valid", rsp_valid, 1'b0);
        next_cycle(); #1;
        check("set3.T3.busy", busy, 1'b1);
        next_cycle(); #1;
        check("set3.T4.busy", busy, 1'b0);

        // B READ addr 3, cell reads 1 and matches the shadow
        req_b = 1'b1; op_b = 2'b10; addr_b = 3'd3; ndro_out = 8'h08;
        chk_gnt("rd3.T", 1'b0, 1'b1);
        next_cycle();
        req_b = 1'b0;
        #1;
        chk_pulse("rd3.T1", 8'h00, 8'h00, 8'h08);
        check("rd3.T1.rsp_valid", rsp_valid, 1'b0);
        next_cycle(); #1;
        check("rd3.T2.rsp_valid", rsp_valid, 1'b0);
        next_cycle(); #1;
        check("rd3.T3.rsp_valid", rsp_valid, 1'b0);
        next_cycle(); #1;
        chk_rsp("rd3.T4", 1'b1, 1'b1, 1'b1, 1'b0);
        next_cycle(); #1;
        chk_rsp("rd3.T5", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rd3.T5.busy", busy, 1'b1);
        next_cycle(); #1;
        check("rd3.T6.busy", busy, 1'b1);
        next_cycle(); #1;
        check("rd3.T7.busy", busy, 1'b0);

        // A READ addr 5, shadow 0 but cell reads 1 -> mismatch
        req_a = 1'b1; op_a = 2'b10; addr_a = 3'd5; ndro_out = 8'h20;
        chk_gnt("rd5.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        #1;
        chk_pulse("rd5.T1", 8'h00, 8'h00, 8'h20);
        skip(3); #1;
        chk_rsp("rd5.T4", 1'b1, 1'b0, 1'b1, 1'b1);
        skip(3);

        // B illegal opcode on addr 3
        req_b = 1'b1; op_b = 2'b11; addr_b = 3'd3;
        chk_gnt("ill.T", 1'b0, 1'b1);
        next_cycle();
        req_b = 1'b0;
        #1;
        chk_pulse("ill.T1", 8'h00, 8'h00, 8'h00);
        chk_rsp("ill.T1", 1'b1, 1'b1, 1'b0, 1'b1);
        skip(3); #1;
        check("ill.T4.busy", busy, 1'b0);

        // A READ addr 3: shadow still 1 after the illegal op -> no error
        req_a = 1'b1; op_a = 2'b10; addr_a = 3'd3; ndro_out = 8'h08;
        chk_gnt("rd3b.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        skip(3); #1;
        chk_rsp("rd3b.T4", 1'b1, 1'b0, 1'b1, 1'b0);
        skip(3);

        // B RESET addr 3
        req_b = 1'b1; op_b = 2'b01; addr_b = 3'd3;
        chk_gnt("rst3.T", 1'b0, 1'b1);
        next_cycle();
        req_b = 1'b0;
        #1;
        chk_pulse("rst3.T1", 8'h00, 8'h08, 8'h00);
        chk_rsp("rst3.T1", 1'b1, 1'b1, 1'b0, 1'b0);
        skip(3);

        // A READ addr 3: shadow now 0, cell still reads 1 -> error
        req_a = 1'b1; op_a = 2'b10; addr_a = 3'd3; ndro_out = 8'h08;
        chk_gnt("rd3c.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        skip(3); #1;
        chk_rsp("rd3c.T4", 1'b1, 1'b0, 1'b1, 1'b1);
        skip(3);

        // Both requesters held from reset: grants alternate A, B, A, B every 4 cycles
        reset = 1'b1;
        req_a = 1'b1; op_a = 2'b00; addr_a = 3'd1;
        req_b = 1'b1; op_b = 2'b01; addr_b = 3'd2;
        ndro_out = 8'h00;
        next_cycle();
        chk_gnt("rr.inrst", 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) next_cycle();
            chk_gnt($sformatf("rr.c%0d", i), (i % 8) == 0, (i % 8) == 4);
        end
        next_cycle();
        req_a = 1'b0; req_b = 1'b0;
        skip(3); #1;
        check("rr.end.busy", busy, 1'b0);

        // Reset in the middle of a READ of addr 1 (shadow[1] = 1 at this point)
        req_a = 1'b1; op_a = 2'b10; addr_a = 3'd1; ndro_out = 8'h02;
        chk_gnt("abort.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        #1;
        chk_pulse("abort.T1", 8'h00, 8'h00, 8'h02);
        next_cycle();
        reset = 1'b1;
        next_cycle(); #1;
        check("abort.T3.busy", busy, 1'b0);
        chk_rsp("abort.T3", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_pulse("abort.T3", 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        next_cycle(); #1;
        check("abort.T4.rsp_valid", rsp_valid, 1'b0);
        check("abort.T4.busy", busy, 1'b0);

        // Shadow cleared by reset: READ addr 1 with cell at 1 reports a mismatch
        req_a = 1'b1; op_a = 2'b10; addr_a = 3'd1; ndro_out = 8'h02;
        chk_gnt("shclr.T", 1'b1, 1'b0);
        next_cycle();
        req_a = 1'b0;
        skip(3); #1;
        chk_rsp("shclr.T4", 1'b1, 1'b0, 1'b1, 1'b1);
        skip(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ndro_bank_scheduler.md
NDRO_BANK_SCHEDULER -- requirements
Module: ndro_bank_scheduler

Interface
REQ-001 SHALL have parameter N_CELLS, default 8: number of NDRO cells driven; address width AW = log2(N_CELLS) = 3.
REQ-002 SHALL have parameter GAP, default 2: idle cycles enforced after every operation before the next grant.
REQ-003 SHALL have parameter READ_LAT, default 2: cycles from the ndro_clk pulse to sampling ndro_out.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have ports req_a, req_b  input  1  requester A/B operation request.
REQ-007 SHALL have ports op_a, op_b  input  2  opcode: 00 SET, 01 RESET, 10 READ, 11 illegal.
REQ-008 SHALL have ports addr_a, addr_b  input  AW  target cell index.
REQ-009 SHALL have ports gnt_a, gnt_b  output  1  one-cycle accept pulse.
REQ-010 SHALL have port rsp_valid  output  1  one-cycle response strobe.
REQ-011 SHALL have port rsp_id  output  1  requester of the response: 0 = A, 1 = B.
REQ-012 SHALL have port rsp_data  output  1  READ result; 0 for other ops.
REQ-013 SHALL have port rsp_err  output  1  illegal op or READ mismatch against shadow.
REQ-014 SHALL have ports ndro_set, ndro_reset, ndro_clk  output  N_CELLS  one-hot, one-cycle pulses to the cell set/reset/clk inputs.
REQ-015 SHALL have port ndro_out  input  N_CELLS  cell readout outputs.
REQ-016 SHALL have port busy  output  1  high in every state other than IDLE.

Function
REQ-017 SHALL implement the FSM IDLE -> ISSUE -> (WAIT_RD -> RESP, READ only) -> HOLD -> IDLE.
REQ-018 SHALL grant only in IDLE: at most one gnt per cycle; op and addr latched at the grant edge; next state ISSUE.
REQ-019 SHALL arbitrate round-robin: on simultaneous req, grant the priority holder; after any grant, priority passes to the other requester; a lone requester is always granted.
REQ-020 SHALL hold a requester's req, op and addr stable until its gnt; the block ignores a req deasserted before gnt.
REQ-021 SHALL in ISSUE (grant T -> cycle T+1) assert exactly one bit: ndro_set[addr] for SET, ndro_reset[addr] for RESET, ndro_clk[addr] for READ; no bit for illegal.
REQ-022 SHALL for SET/RESET/illegal assert rsp_valid in cycle T+1 with rsp_data = 0 and rsp_err = 1 only for illegal.
REQ-023 SHALL for READ stay READ_LAT cycles in WAIT_RD (T+2..T+1+READ_LAT), sample ndro_out[addr] on the last of these, then pulse rsp_valid in RESP at T+2+READ_LAT with rsp_data = the sample.
REQ-024 SHALL keep a shadow bit per cell: SET writes 1, RESET writes 0, READ and illegal leave it unchanged; READ sets rsp_err = (sample != shadow[addr]).
REQ-025 SHALL stay GAP cycles in HOLD after ISSUE (writes/illegal) or RESP (READ); with defaults the earliest next grant is T+4 after a write and T+7 after a READ.
REQ-026 SHALL keep rsp_id equal to the granted requester, and hold rsp_id, rsp_data and rsp_err at 0 while rsp_valid is 0.
REQ-027 SHALL ignore out-of-range addr (>= N_CELLS when not a power of two): treat it as illegal.
REQ-028 SHALL never assert more than one bit across ndro_set, ndro_reset and ndro_clk in any cycle.

Reset
REQ-029 SHALL on reset go to IDLE, clear all outputs to 0, clear all shadow bits to 0, and give priority to A.
REQ-030 SHALL let reset asserted mid-operation abort it: no rsp_valid; all pulse outputs are 0 from the next edge.

Verification
REQ-031 SHALL pass: A SET addr 3 at T -> gnt_a at T, ndro_set = 8'h08 at T+1, rsp_valid/rsp_id = 0/rsp_err = 0 at T+1, busy low at T+4.
REQ-032 SHALL pass: after SET 3, B READ addr 3 with ndro_out[3] = 1 -> ndro_clk = 8'h08 at T+1, rsp_valid at T+4 with rsp_id = 1, rsp_data = 1, rsp_err = 0.
REQ-033 SHALL pass: READ addr 5 (shadow 0) with ndro_out[5] = 1 -> rsp_data = 1, rsp_err = 1.
REQ-034 SHALL pass: req_a and req_b held continuously from reset -> grant order A, B, A, B; no grant while busy.
REQ-035 SHALL pass: op = 11 -> gnt, no ndro pulse, rsp_valid with rsp_err = 1 at T+1; shadow unchanged.
REQ-036 SHALL pass: reset asserted at T+2 of a READ -> no rsp_valid, busy = 0 and shadow all 0 at the following cycle.
